// File: rtl/sum_pkt_pkg.sv
// Shared constants for the accumulator -> byte-packer link.
// Also used by the accumulator-side bench.
package sum_pkt_pkg;

  localparam int unsigned SUM_W           = 10;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned SUMS_PER_FRAME  = 4;
  localparam int unsigned BYTES_PER_FRAME = SUM_W * SUMS_PER_FRAME / BYTE_W;

  // Counter width for an index ranging over 0..n-1; at least 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sum_frame_filler.sv
// Fill side of the packer: collects GROUP sums into one frame and holds it
// (fill_full) until the drain side takes it.
module sum_frame_filler
  import sum_pkt_pkg::*;
#(
  parameter int unsigned IN_W  = SUM_W,
  parameter int unsigned GROUP = SUMS_PER_FRAME
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  xfer,
  output logic                  fill_cmplt,
  output logic [IN_W*GROUP-1:0] fill_frame
);

  localparam int unsigned IdxW = idx_width(GROUP);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(GROUP - 1);

  logic [IdxW-1:0]       word_idx_q, word_idx_d;
  logic [IN_W*GROUP-1:0] fill_buf_q;
  logic                  fill_full_q, fill_full_d;
  logic                  accept;
  logic                  last_word;

  assign s_ready    = ~fill_full_q;
  assign accept     = s_valid & s_ready;
  assign last_word  = (word_idx_q == LastIdx);
  assign fill_cmplt = fill_full_q | (accept & last_word);

  // Frame as it will look after this edge, so a transfer can include the word
  // being written in the same cycle.
  always_comb begin
    fill_frame = fill_buf_q;
    if (accept) begin
      fill_frame[word_idx_q*IN_W +: IN_W] = s_data;
    end
  end

  always_comb begin
    word_idx_d = word_idx_q;
    if (accept) begin
      word_idx_d = last_word ? '0 : word_idx_q + 1'b1;
    end
  end

  always_comb begin
    fill_full_d = fill_full_q;
    if (xfer) begin
      fill_full_d = 1'b0;
    end else if (fill_cmplt) begin
      fill_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx_q  <= '0;
      fill_buf_q  <= '0;
      fill_full_q <= 1'b0;
    end else begin
      word_idx_q  <= word_idx_d;
      fill_buf_q  <= fill_frame;
      fill_full_q <= fill_full_d;
    end
  end

endmodule

// File: rtl/sum_byte_packer.sv
// Packs GROUP IN_W-bit sums into a little-endian frame and streams it out as
// OUT_W-bit bytes; ping-pong fill/drain buffers overlap collection and output.
module sum_byte_packer
  import sum_pkt_pkg::*;
#(
  parameter int unsigned IN_W  = SUM_W,
  parameter int unsigned OUT_W = BYTE_W,
  parameter int unsigned GROUP = SUMS_PER_FRAME
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             frame_done
);

  localparam int unsigned FrameW = IN_W * GROUP;
  localparam int unsigned NBYTES = FrameW / OUT_W;
  localparam int unsigned ByteIdxW = idx_width(NBYTES);
  localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(NBYTES - 1);

  if ((FrameW % OUT_W) != 0) begin : g_bad_width
    $error("sum_byte_packer: IN_W*GROUP must be a multiple of OUT_W");
  end

  logic [FrameW-1:0]   fill_frame;
  logic                fill_cmplt;
  logic                xfer;
  logic [FrameW-1:0]   drain_buf_q, drain_buf_d;
  logic                drain_full_q, drain_full_d;
  logic [ByteIdxW-1:0] byte_idx_q, byte_idx_d;
  logic                byte_accept;
  logic                last_byte;
  logic                last_accept;

  sum_frame_filler #(
    .IN_W  (IN_W),
    .GROUP (GROUP)
  ) u_filler (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .xfer       (xfer),
    .fill_cmplt (fill_cmplt),
    .fill_frame (fill_frame)
  );

  assign byte_accept = drain_full_q & m_ready;
  assign last_byte   = (byte_idx_q == LastByte);
  assign last_accept = byte_accept & last_byte;
  // Drain buffer is free now or frees up on this edge.
  assign xfer        = fill_cmplt & (~drain_full_q | last_accept);

  assign m_valid    = drain_full_q;
  assign m_data     = drain_buf_q[byte_idx_q*OUT_W +: OUT_W];
  assign m_last     = drain_full_q & last_byte;
  assign frame_done = last_accept;

  always_comb begin
    drain_buf_d  = drain_buf_q;
    drain_full_d = drain_full_q;
    byte_idx_d   = byte_idx_q;
    if (byte_accept) begin
      byte_idx_d = last_byte ? '0 : byte_idx_q + 1'b1;
    end
    if (xfer) begin
      drain_buf_d  = fill_frame;
      drain_full_d = 1'b1;
    end else if (last_accept) begin
      drain_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_buf_q  <= '0;
      drain_full_q <= 1'b0;
      byte_idx_q   <= '0;
    end else begin
      drain_buf_q  <= drain_buf_d;
      drain_full_q <= drain_full_d;
      byte_idx_q   <= byte_idx_d;
    end
  end

endmodule

// File: tb/tb_sum_byte_packer.sv
// Directed and random checks for sum_byte_packer: table of hand-packed frames,
// back-to-back streaming, back-pressure, reset mid-frame and a random soak.
module tb_sum_byte_packer;
  import sum_pkt_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b0;
  logic       frame_done;

  sum_byte_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [9:0] a, input logic [9:0] b,
                                            input logic [9:0] c, input logic [9:0] d,
                                            input int k);
    logic [39:0] f;
    f = {d, c, b, a};
    return f[8*k +: 8];
  endfunction

  // Negedge monitor: records handshakes and checks output stability under stall.
  logic [7:0] got_q[$];
  logic       got_last_q[$];
  int         got_cyc_q[$];
  logic [9:0] acc_q[$];
  int         cyc = 0;
  int         n_fdone = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, prev_data);
          check("stall_last", m_last, prev_last);
        end
        if (m_valid && m_ready) begin
          got_q.push_back(m_data);
          got_last_q.push_back(m_last);
          got_cyc_q.push_back(cyc);
        end
        if (s_valid && s_ready) acc_q.push_back(s_data);
        if (frame_done) n_fdone++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  logic       smp_sready;
  logic       smp_mvalid;
  logic [7:0] smp_mdata;

  // Drive at posedge+1, sample at negedge, return at next posedge+1.
  task automatic step(input logic sv, input logic [9:0] sd, input logic mr);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    @(negedge clk);
    smp_sready = s_ready;
    smp_mvalid = m_valid;
    smp_mdata  = m_data;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_last_q.delete();
    got_cyc_q.delete();
    acc_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 1);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #2;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0][9:0] sums;
    logic [4:0][7:0] bytes;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int v);
    int fd0;
    clear_mon();
    fd0 = n_fdone;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, vecs[v].sums[k], 1'b1);
      check($sformatf("v%0d_sready%0d", v, k), smp_sready, 1);
    end
    step(1'b0, 10'h0, 1'b1);
    check($sformatf("v%0d_latency", v), smp_mvalid, 1);
    for (int c = 0; c < 20 && got_q.size() < 5; c++) step(1'b0, 10'h0, 1'b1);
    check($sformatf("v%0d_nbytes", v), got_q.size(), 5);
    for (int k = 0; k < 5 && k < got_q.size(); k++) begin
      check($sformatf("v%0d_byte%0d", v, k), got_q[k], vecs[v].bytes[k]);
      check($sformatf("v%0d_last%0d", v, k), got_last_q[k], (k == 4));
    end
    check($sformatf("v%0d_frame_done", v), n_fdone - fd0, 1);
  endtask

  logic [9:0] sv3[12];

  initial begin
    vecs[0].sums  = {10'h004, 10'h003, 10'h002, 10'h001};
    vecs[0].bytes = {8'h01, 8'h00, 8'h30, 8'h08, 8'h01};
    vecs[1].sums  = {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
    vecs[1].bytes = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[2].sums  = {10'h000, 10'h000, 10'h000, 10'h000};
    vecs[2].bytes = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].sums  = {10'h155, 10'h2AA, 10'h155, 10'h2AA};
    vecs[3].bytes = {8'h55, 8'h6A, 8'hA5, 8'h56, 8'hAA};
    vecs[4].sums  = {10'h0F0, 10'h3C0, 10'h045, 10'h123};
    vecs[4].bytes = {8'h3C, 8'h3C, 8'h01, 8'h15, 8'h23};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table of single frames
    for (int v = 0; v < 5; v++) run_vec(v);

    // Back-to-back frames: no output gap, input never stalls
    clear_mon();
    for (int f = 1; f <= 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        step(1'b1, vecs[f].sums[k], 1'b1);
        check($sformatf("b2b_sready_f%0d_%0d", f, k), smp_sready, 1);
      end
    end
    for (int c = 0; c < 30 && got_q.size() < 10; c++) step(1'b0, 10'h0, 1'b1);
    check("b2b_nbytes", got_q.size(), 10);
    for (int j = 0; j < 10 && j < got_q.size(); j++) begin
      check($sformatf("b2b_byte%0d", j), got_q[j], (j < 5) ? 8'hFF : 8'h00);
    end
    if (got_q.size() == 10) check("b2b_no_gap", got_cyc_q[9] - got_cyc_q[0], 9);

    // Output held off: two frames fill, input stalls, then everything drains
    begin
      int idx;
      idx = 0;
      clear_mon();
      for (int i = 0; i < 12; i++) sv3[i] = 10'(i * 37 + 5);
      for (int c = 0; c < 20; c++) begin
        step(1'b1, sv3[(idx < 12) ? idx : 11], 1'b0);
        if (smp_sready) idx++;
      end
      check("bp_accepted", acc_q.size(), 8);
      check("bp_sready_low", smp_sready, 0);
      check("bp_mvalid", smp_mvalid, 1);
      check("bp_mdata_byte0", smp_mdata, model_byte(sv3[0], sv3[1], sv3[2], sv3[3], 0));
      check("bp_no_bytes", got_q.size(), 0);
      for (int c = 0; c < 60 && !(got_q.size() >= 15 && idx == 12); c++) begin
        if (idx < 12) begin
          step(1'b1, sv3[idx], 1'b1);
          if (smp_sready) idx++;
        end else begin
          step(1'b0, 10'h0, 1'b1);
        end
      end
      check("bp_accepted_all", acc_q.size(), 12);
      check("bp_nbytes", got_q.size(), 15);
      for (int j = 0; j < 15 && j < got_q.size(); j++) begin
        int f;
        f = j / 5;
        check($sformatf("bp_byte%0d", j), got_q[j],
              model_byte(sv3[4*f], sv3[4*f+1], sv3[4*f+2], sv3[4*f+3], j % 5));
      end
    end

    // Toggling m_ready during drain
    clear_mon();
    for (int k = 0; k < 4; k++) step(1'b1, vecs[4].sums[k], 1'b0);
    for (int c = 0; c < 30 && got_q.size() < 5; c++) step(1'b0, 10'h0, (c % 2) == 0);
    repeat (3) step(1'b0, 10'h0, 1'b1);
    check("tog_nbytes", got_q.size(), 5);
    for (int k = 0; k < 5 && k < got_q.size(); k++) begin
      check($sformatf("tog_byte%0d", k), got_q[k], vecs[4].bytes[k]);
    end

    // Reset with a partial frame, then mid-drain at byte 2
    step(1'b1, 10'h3AB, 1'b1);
    step(1'b1, 10'h1CD, 1'b1);
    apply_reset("rst_fill");
    run_vec(0);
    clear_mon();
    for (int k = 0; k < 4; k++) step(1'b1, vecs[3].sums[k], 1'b1);
    step(1'b0, 10'h0, 1'b1);
    step(1'b0, 10'h0, 1'b1);
    check("rst_drain_pre_bytes", got_q.size(), 2);
    apply_reset("rst_drain");
    run_vec(0);

    // Random soak against the packing model
    begin
      int fd0;
      clear_mon();
      fd0 = n_fdone;
      for (int c = 0; c < 40000 && got_q.size() < 5000; c++) begin
        step((acc_q.size() < 4000) && ($urandom_range(0, 3) != 0), 10'($urandom),
             $urandom_range(0, 3) != 0);
      end
      check("rnd_nsums", acc_q.size(), 4000);
      check("rnd_nbytes", got_q.size(), 5000);
      check("rnd_frame_done", n_fdone - fd0, 1000);
      for (int j = 0; j < 5000 && j < got_q.size() && (j / 5) * 4 + 3 < acc_q.size(); j++) begin
        int f;
        f = j / 5;
        check($sformatf("rnd_byte%0d", j), got_q[j],
              model_byte(acc_q[4*f], acc_q[4*f+1], acc_q[4*f+2], acc_q[4*f+3], j % 5));
        check($sformatf("rnd_last%0d", j), got_last_q[j], (j % 5) == 4);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
